fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch engine feeding a small FIFO of fetched words.
//
// A three-state controller (IDLE / WAIT / DISCARD) keeps at most one memory
// read in flight. Each returned word is queued together with the address it
// was fetched from. A redirect flushes the queue and restarts fetching at a
// new address. If a redirect arrives while a read is still outstanding, that
// read's late response is thrown away in DISCARD.
//
// Ports:
//   clk, reset          single clock; synchronous active-high reset
//   redirect/redirectPc taken branch/jump and its target address
//   memReq/memAddr      one-cycle read request to instruction memory
//   memValid/memData    read response (honoured only in WAIT/DISCARD)
//   instValid/instOut/pcOut  queue head (instruction word and its address)
//   instReady           consumer accepts the head this cycle
module fetch_queue #(
    parameter int DBITS    = 32,
    parameter int START_PC = 64,
    parameter int DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect,
    input  logic [DBITS-1:0] redirectPc,
    output logic             memReq,
    output logic [DBITS-1:0] memAddr,
    input  logic             memValid,
    input  logic [DBITS-1:0] memData,
    output logic             instValid,
    output logic [DBITS-1:0] instOut,
    output logic [DBITS-1:0] pcOut,
    input  logic             instReady
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t           state;
    logic [DBITS-1:0] fetch_pc;
    logic [DBITS-1:0] req_pc;     // address of the read currently in flight
    logic [DBITS-1:0] pc_mem   [DEPTH];
    logic [DBITS-1:0] data_mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      count;
    logic             push, pop;

    // A new request is issued only while the queue has room. A word that is
    // pushed therefore always has a free slot waiting for it.
    assign memReq    = !reset && (state == IDLE) && (count < FULL) && !redirect;
    assign memAddr   = fetch_pc;
    assign instValid = !reset && (count != '0);
    assign instOut   = data_mem[rd_ptr];
    assign pcOut     = pc_mem[rd_ptr];

    // A response that coincides with a redirect belongs to the old path.
    assign push = (state == WAIT) && memValid && !redirect;
    assign pop  = instValid && instReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= DBITS'(START_PC);
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memReq) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + DBITS'(4);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (memValid)
                        state <= IDLE;
                    else if (redirect)
                        state <= DISCARD;   // response still owed; drop it later
                end
                DISCARD: begin
                    if (memValid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // memReq is low whenever redirect is high, so this never
            // collides with the increment above.
            if (redirect)
                fetch_pc <= redirectPc;

            // A flush wins over any pop or push in the same cycle.
            if (redirect) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    pc_mem[wr_ptr]   <= req_pc;
                    data_mem[wr_ptr] <= memData;
                    wr_ptr           <= wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule
